// File: rtl/fisqr_pkg.sv
// fisqr_pkg: shared float format constants, the in-flight tag type and the operand error test
//   FP_W/EXP_W/MAN_W  : 27-bit float layout (1 sign, 8 exponent, 18 mantissa)
//   SIGN_BIT/EXP_*    : field positions inside an operand
//   EXP_ZERO/EXP_INF  : exponent codes the unit cannot handle
//   isq_tag_t         : {valid, id, err} tracked alongside each operand in the unit
package fisqr_pkg;
  localparam int FP_W = 27;
  localparam int EXP_W = 8;
  localparam int MAN_W = 18;
  localparam int SIGN_BIT = 26;
  localparam int EXP_MSB = 25;
  localparam int EXP_LSB = 18;
  localparam logic [EXP_W-1:0] EXP_ZERO = 8'h00;
  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;
  // wide enough for the largest supported requester count (8)
  localparam int TAG_ID_W = 3;
  typedef struct packed {
    logic valid;
    logic [TAG_ID_W-1:0] id;
    logic err;
  } isq_tag_t;
  // negative, zero/denormal and inf/nan operands have no meaningful inverse square root
  function automatic logic isq_bad(input logic sign, input logic [EXP_W-1:0] exp_f);
    return sign || exp_f == EXP_ZERO || exp_f == EXP_INF;
  endfunction
endpackage

// File: rtl/fisqr_sched_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter with a rotating priority pointer
//   clk_i, rst_ni : clock, synchronous active-low reset
//   req_i         : request vector
//   hold_i        : suppresses every grant
//   advance_i     : a grant was taken this cycle; move the pointer past it
//   gnt_o         : one-hot grant (combinational)
//   ptr_o         : current highest-priority index
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_i,
  input  logic                 hold_i,
  input  logic                 advance_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] ptr_o
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] ptr_q, ptr_d, idx, j;
  logic found;
  // walk from the pointer with explicit wrap so non-power-of-two N stays in range
  always_comb begin
    found = 1'b0;
    idx = ptr_q;
    j = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[j]) begin
        found = 1'b1;
        idx = j;
      end
      j = (j == PW'(N - 1)) ? '0 : j + 1'b1;
    end
  end
  assign gnt_o = (found && !hold_i) ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
  assign ptr_d = advance_i ? ((idx == PW'(N - 1)) ? '0 : idx + 1'b1) : ptr_q;
  assign ptr_o = ptr_q;
  always_ff @(posedge clk_i)
    ptr_q <= !rst_ni ? '0 : ptr_d;
endmodule

// File: rtl/fisqr_sched.sv
// fisqr_sched: shares one pipelined inverse-square-root unit among N_REQ requesters
//   i_clk, i_rst          : clock, synchronous active-low reset
//   i_req_valid/_data     : per-requester operands (27 bits each, requester i at [27i+26:27i])
//   o_req_ready           : one-hot grant, combinational
//   i_hold                : blocks new grants while in-flight work drains
//   o_isq_x / i_isq_y     : operand to / result from the unit (LATENCY cycles apart)
//   o_rsp_valid/_data/_err: registered one-hot response strobe, shared data, error flag
//   o_inflight, o_idle    : accepted-but-unreturned count, and nothing-to-do indicator
module fisqr_sched
  import fisqr_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LATENCY = 5
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [N_REQ-1:0]                i_req_valid,
  input  logic [N_REQ*FP_W-1:0]           i_req_data,
  output logic [N_REQ-1:0]                o_req_ready,
  input  logic                            i_hold,
  output logic [FP_W-1:0]                 o_isq_x,
  input  logic [FP_W-1:0]                 i_isq_y,
  output logic [N_REQ-1:0]                o_rsp_valid,
  output logic [FP_W-1:0]                 o_rsp_data,
  output logic                            o_rsp_err,
  output logic [$clog2(LATENCY+2)-1:0]    o_inflight,
  output logic                            o_idle
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(LATENCY + 2);
  logic [IW-1:0] gidx, rr_ptr;
  logic gnt;
  isq_tag_t tag_d, tail;
  isq_tag_t pipe_q [LATENCY];
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [FP_W-1:0] rsp_data_q, rsp_data_d;
  logic rsp_err_q, rsp_err_d;
  logic [CW-1:0] inflight_q, inflight_d;
  // holding the arbiter during reset keeps o_req_ready low while i_rst is asserted
  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk_i    (i_clk),
    .rst_ni   (i_rst),
    .req_i    (i_req_valid),
    .hold_i   (i_hold | ~i_rst),
    .advance_i(gnt),
    .gnt_o    (o_req_ready),
    .ptr_o    (rr_ptr)
  );
  assign gnt = |o_req_ready;
  always_comb begin
    gidx = '0;
    o_isq_x = '0;
    for (int k = 0; k < N_REQ; k++)
      if (o_req_ready[k]) begin
        gidx = IW'(k);
        o_isq_x = i_req_data[FP_W*k +: FP_W];
      end
  end
  // bad operands still enter the unit so every tag sits exactly LATENCY stages deep
  assign tag_d = '{valid: gnt, id: TAG_ID_W'(gidx),
                   err: gnt && isq_bad(o_isq_x[SIGN_BIT], o_isq_x[EXP_MSB:EXP_LSB])};
  assign tail = pipe_q[LATENCY-1];
  assign rsp_valid_d = tail.valid ? ({{(N_REQ-1){1'b0}}, 1'b1} << tail.id) : '0;
  assign rsp_err_d = tail.valid && tail.err;
  assign rsp_data_d = (tail.valid && !tail.err) ? i_isq_y : '0;
  assign inflight_d = inflight_q + CW'(gnt) - CW'(|rsp_valid_q);
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int k = 0; k < LATENCY; k++) pipe_q[k] <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      inflight_q <= '0;
    end else begin
      pipe_q[0] <= tag_d;
      for (int k = 1; k < LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      inflight_q <= inflight_d;
    end
  end
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data = rsp_data_q;
  assign o_rsp_err = rsp_err_q;
  assign o_inflight = inflight_q;
  assign o_idle = (inflight_q == '0) && !(|i_req_valid);
  // a pending requester sitting at the pointer must be the one granted
  assert property (@(posedge i_clk) disable iff (!i_rst)
    gnt |-> (o_req_ready[rr_ptr] || !i_req_valid[rr_ptr]));
endmodule

// File: tb/tb_fisqr_sched.sv
// tb_fisqr_sched: directed stimulus against a queue-based model of fisqr_sched plus a stand-in unit
module tb_fisqr_sched;
  localparam int N = 4;
  localparam int L = 5;
  localparam logic [26:0] K = 27'h0555555;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  logic i_hold = 1'b0;
  logic [N-1:0] i_req_valid = '0;
  logic [26:0] d [N];
  logic [N*27-1:0] i_req_data;
  logic [N-1:0] o_req_ready, o_rsp_valid;
  logic [26:0] o_isq_x, i_isq_y, o_rsp_data;
  logic o_rsp_err, o_idle;
  logic [2:0] o_inflight;
  logic [26:0] ux [L+1];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ptr = 0;
  bit chk_en = 0;
  typedef struct {
    int due;
    logic [N-1:0] oh;
    logic [26:0] dat;
    logic e;
  } exp_t;
  exp_t q [$];

  fisqr_sched #(.N_REQ(N), .LATENCY(L)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .i_hold(i_hold), .o_isq_x(o_isq_x), .i_isq_y(i_isq_y),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_inflight(o_inflight), .o_idle(o_idle)
  );

  always #5 i_clk = ~i_clk;
  assign i_req_data = {d[3], d[2], d[1], d[0]};
  // stand-in unit: y = x ^ K, LATENCY cycles after x was presented
  assign i_isq_y = ux[L] ^ K;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic bad(input logic [26:0] x);
    return x[26] || x[25:18] == 8'h00 || x[25:18] == 8'hFF;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_rsp(input string nm, input logic [N-1:0] oh, input logic [26:0] dat, input logic e);
    bit seen = 0;
    for (int n = 0; n < 12 && !seen; n++) begin
      @(negedge i_clk);
      if (o_rsp_valid != 0) begin
        seen = 1;
        chk({nm, "_id"}, 32'(o_rsp_valid), 32'(oh));
        chk({nm, "_data"}, 32'(o_rsp_data), 32'(dat));
        chk({nm, "_err"}, 32'(o_rsp_err), 32'(e));
      end
    end
    chk({nm, "_seen"}, 32'(seen), 32'd1);
  endtask

  // model: grants by round-robin rule, responses due LATENCY+1 cycles after grant in grant order
  always @(negedge i_clk) begin
    int g;
    logic [1:0] gi;
    logic [N-1:0] er;
    logic [26:0] ex;
    exp_t h;
    bit pop;
    for (int k = L; k > 0; k--) ux[k] = ux[k-1];
    ux[0] = o_isq_x;
    if (chk_en) begin
      g = -1;
      if (i_rst && !i_hold)
        for (int k = 0; k < N; k++)
          if (g < 0 && i_req_valid[2'((ptr + k) % N)]) g = (ptr + k) % N;
      gi = 2'(g);
      er = (g < 0) ? '0 : (4'd1 << gi);
      ex = (g < 0) ? '0 : d[gi];
      chk("ready", 32'(o_req_ready), 32'(er));
      chk("isq_x", 32'(o_isq_x), 32'(ex));
      pop = q.size() > 0 && q[0].due == cyc;
      h = pop ? q[0] : '{due: 0, oh: '0, dat: '0, e: 1'b0};
      chk("rsp_valid", 32'(o_rsp_valid), 32'(h.oh));
      chk("rsp_data", 32'(o_rsp_data), 32'(h.dat));
      chk("rsp_err", 32'(o_rsp_err), 32'(h.e));
      chk("inflight", 32'(o_inflight), q.size());
      chk("idle", 32'(o_idle), 32'(q.size() == 0 && i_req_valid == 0));
      if (pop) void'(q.pop_front());
      if (!i_rst) begin
        q.delete();
        ptr = 0;
      end else if (g >= 0) begin
        q.push_back('{due: cyc + L + 1, oh: er, dat: bad(ex) ? 27'd0 : ex ^ K, e: bad(ex)});
        ptr = (g + 1) % N;
      end
    end
    cyc++;
  end

  initial begin
    int lat, cnt, first, got, mx;
    for (int k = 0; k <= L; k++) ux[k] = '0;
    for (int k = 0; k < N; k++) d[k] = 27'h1FC0000;
    // reset with requests pending: nothing may be granted
    i_req_valid = 4'hF;
    step();
    step();
    chk_en = 1;
    @(negedge i_clk);
    chk("rst_ready", 32'(o_req_ready), 32'd0);
    chk("rst_inflight", 32'(o_inflight), 32'd0);
    chk("rst_rsp", 32'(o_rsp_valid), 32'd0);
    step();
    i_rst = 1'b1;
    // requester 1 waits while 0 is granted, then gets in next cycle
    d[0] = 27'h2000000;
    d[1] = 27'h1E00000;
    i_req_valid = 4'b0011;
    @(negedge i_clk);
    chk("t6_g0", 32'(o_req_ready), 32'h1);
    step();
    i_req_valid = 4'b0010;
    @(negedge i_clk);
    chk("t6_g1", 32'(o_req_ready), 32'h2);
    chk("t6_x1", 32'(o_isq_x), 32'h1E00000);
    step();
    i_req_valid = '0;
    wait_rsp("t6_r0", 4'b0001, 27'h2555555, 1'b0);
    wait_rsp("t6_r1", 4'b0010, 27'h1B55555, 1'b0);
    // single 1.0 operand: response LATENCY+1 cycles after grant
    step();
    d[0] = 27'h1FC0000;
    i_req_valid = 4'b0001;
    @(negedge i_clk);
    chk("t1_g", 32'(o_req_ready), 32'h1);
    step();
    i_req_valid = '0;
    @(negedge i_clk);
    chk("t1_inf1", 32'(o_inflight), 32'd1);
    lat = 1;
    while (o_rsp_valid == 0 && lat < 12) begin
      @(negedge i_clk);
      lat++;
    end
    chk("t1_lat", lat, 32'd6);
    chk("t1_id", 32'(o_rsp_valid), 32'h1);
    chk("t1_data", 32'(o_rsp_data), 32'h1A95555);
    chk("t1_err", 32'(o_rsp_err), 32'd0);
    step();
    @(negedge i_clk);
    chk("t1_inf0", 32'(o_inflight), 32'd0);
    chk("t1_idle", 32'(o_idle), 32'd1);
    // error operands around a good one
    step();
    d[2] = 27'h4000000;
    i_req_valid = 4'b0100;
    @(negedge i_clk);
    chk("t3_g2", 32'(o_req_ready), 32'h4);
    step();
    i_req_valid = 4'b0001;
    @(negedge i_clk);
    chk("t3_g0", 32'(o_req_ready), 32'h1);
    step();
    d[3] = 27'h0000123;
    i_req_valid = 4'b1000;
    @(negedge i_clk);
    chk("t3_g3", 32'(o_req_ready), 32'h8);
    step();
    i_req_valid = '0;
    wait_rsp("t3_r2", 4'b0100, 27'd0, 1'b1);
    wait_rsp("t3_r0", 4'b0001, 27'h1A95555, 1'b0);
    wait_rsp("t3_r3", 4'b1000, 27'd0, 1'b1);
    // hold with three in flight
    step();
    d[1] = 27'h2000000;
    d[2] = 27'h1E00000;
    d[3] = 27'h0C00000;
    i_req_valid = 4'b0111;
    step();
    i_req_valid = 4'b0110;
    step();
    i_req_valid = 4'b0100;
    step();
    i_req_valid = 4'b1011;
    i_hold = 1'b1;
    cnt = 0;
    @(negedge i_clk);
    chk("t4_inf3", 32'(o_inflight), 32'd3);
    for (int n = 0; n < L + 3; n++) begin
      chk("t4_noready", 32'(o_req_ready), 32'd0);
      if (o_rsp_valid != 0) cnt++;
      @(negedge i_clk);
    end
    chk("t4_rsp_cnt", cnt, 32'd3);
    step();
    i_req_valid = '0;
    @(negedge i_clk);
    chk("t4_idle", 32'(o_idle), 32'd1);
    chk("t4_inf0", 32'(o_inflight), 32'd0);
    // reset with four in flight
    step();
    i_hold = 1'b0;
    i_req_valid = 4'hF;
    repeat (4) step();
    i_req_valid = '0;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("t5_inf4", 32'(o_inflight), 32'd4);
    step();
    i_rst = 1'b1;
    cnt = 0;
    for (int n = 0; n < L + 4; n++) begin
      @(negedge i_clk);
      if (o_rsp_valid != 0) cnt++;
    end
    chk("t5_no_rsp", cnt, 32'd0);
    chk("t5_inf0", 32'(o_inflight), 32'd0);
    // full load from pointer 0: 12 grants, 12 back-to-back responses
    step();
    got = 0;
    first = -1;
    mx = 0;
    for (int n = 0; n < 26; n++) begin
      i_req_valid = (n < 12) ? 4'hF : 4'h0;
      @(negedge i_clk);
      if (n < 12) chk("t2_order", 32'(o_req_ready), 32'(4'd1 << (n % 4)));
      if (int'(o_inflight) > mx) mx = int'(o_inflight);
      if (o_rsp_valid != 0) begin
        if (got == 0) first = n;
        chk("t2_rsp_id", 32'(o_rsp_valid), 32'(4'd1 << (got % 4)));
        chk("t2_b2b", n - first, got);
        got++;
      end
      step();
    end
    chk("t2_count", got, 32'd12);
    chk("t2_first", first, 32'd6);
    chk("t2_peak", mx, 32'd6);
    @(negedge i_clk);
    chk("t2_idle", 32'(o_idle), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
